// File: rtl/aer_out_event_fifo.sv
// Elastic FIFO on the outgoing AER path. Both sides use a 4-phase handshake.
// Optional statistics counters are built in when AER_FIFO_STATS_EN is defined.
module aer_out_event_fifo #(
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 16,
    parameter int LVL_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  AERIN_REQ,
    input  logic [ADDR_WIDTH-1:0] AERIN_ADDR,
    output logic                  AERIN_ACK,
    output logic                  AEROUT_REQ,
    output logic [ADDR_WIDTH-1:0] AEROUT_ADDR,
    input  logic                  AEROUT_ACK,
    input  logic                  FLUSH,
    output logic [LVL_WIDTH-1:0]  LEVEL,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [31:0]           EVT_CNT,
    output logic [LVL_WIDTH-1:0]  MAX_LEVEL
);

    localparam int IDX_WIDTH = LVL_WIDTH - 1;

    typedef enum logic {
        IN_IDLE,
        IN_ACK
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_REQ,
        OUT_WAIT
    } out_state_t;

    logic [ADDR_WIDTH-1:0] mem [DEPTH];

    logic [LVL_WIDTH-1:0]  wr_ptr, wr_ptr_next;
    logic [LVL_WIDTH-1:0]  rd_ptr, rd_ptr_next;
    logic [LVL_WIDTH-1:0]  level_q, level_next;
    logic                  full_q, full_next;
    logic                  empty_q, empty_next;
    logic [IDX_WIDTH-1:0]  wr_idx, rd_idx;

    in_state_t             in_state, in_state_next;
    out_state_t            out_state, out_state_next;
    logic                  ack_q, ack_next;
    logic                  out_vld, out_vld_next;
    logic [ADDR_WIDTH-1:0] out_addr, out_addr_next;
    logic                  wr_en, rd_en;

    assign wr_idx = wr_ptr[IDX_WIDTH-1:0];
    assign rd_idx = rd_ptr[IDX_WIDTH-1:0];

    // Input side: accept one event per request, hold ACK until REQ falls.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        in_state_next = in_state;
        ack_next      = ack_q;
        wr_en         = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (AERIN_REQ && !full_q) begin
                    wr_en         = 1'b1;
                    ack_next      = 1'b1;
                    in_state_next = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!AERIN_REQ) begin
                    ack_next      = 1'b0;
                    in_state_next = IN_IDLE;
                end
            end
            default: begin
                ack_next      = 1'b0;
                in_state_next = IN_IDLE;
            end
        endcase
    end

    // Output side: a FLUSH cycle never loads, so the flushed head is not presented.
    always_comb begin
        out_state_next = out_state;
        out_vld_next   = out_vld;
        out_addr_next  = out_addr;
        rd_en          = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (!empty_q && !FLUSH) begin
                    rd_en          = 1'b1;
                    out_addr_next  = mem[rd_idx];
                    out_vld_next   = 1'b1;
                    out_state_next = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (AEROUT_ACK) begin
                    out_vld_next   = 1'b0;
                    out_state_next = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!AEROUT_ACK) begin
                    out_state_next = OUT_IDLE;
                end
            end
            default: begin
                out_vld_next   = 1'b0;
                out_state_next = OUT_IDLE;
            end
        endcase
    end

    // A flush moves rd_ptr to the old wr_ptr, so a same-cycle write survives as the sole entry.
    always_comb begin
        wr_ptr_next = wr_ptr + LVL_WIDTH'(wr_en);
        rd_ptr_next = FLUSH ? wr_ptr : rd_ptr + LVL_WIDTH'(rd_en);
        level_next  = wr_ptr_next - rd_ptr_next;
        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[IDX_WIDTH-1:0] == rd_ptr_next[IDX_WIDTH-1:0]) &&
                      (wr_ptr_next[IDX_WIDTH] != rd_ptr_next[IDX_WIDTH]);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state  <= IN_IDLE;
            out_state <= OUT_IDLE;
            ack_q     <= 1'b0;
            out_vld   <= 1'b0;
            out_addr  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            in_state  <= in_state_next;
            out_state <= out_state_next;
            ack_q     <= ack_next;
            out_vld   <= out_vld_next;
            out_addr  <= out_addr_next;
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            level_q   <= level_next;
            full_q    <= full_next;
            empty_q   <= empty_next;
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= AERIN_ADDR;
        end
    end

    assign AERIN_ACK   = ack_q;
    assign AEROUT_REQ  = out_vld;
    assign AEROUT_ADDR = out_addr;
    assign LEVEL       = level_q;
    assign FULL        = full_q;
    assign EMPTY       = empty_q;

`ifdef AER_FIFO_STATS_EN
    logic [31:0]          evt_cnt;
    logic [LVL_WIDTH-1:0] max_level;

    // Statistics survive FLUSH; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt   <= '0;
            max_level <= '0;
        end else begin
            if (wr_en) begin
                evt_cnt <= evt_cnt + 32'd1;
            end
            if (level_next > max_level) begin
                max_level <= level_next;
            end
        end
    end

    assign EVT_CNT   = evt_cnt;
    assign MAX_LEVEL = max_level;
`else
    assign EVT_CNT   = '0;
    assign MAX_LEVEL = '0;
`endif

    write_never_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(wr_en && full_q)
    );

endmodule

// File: tb/tb_aer_out_event_fifo.sv
// Self-checking bench for aer_out_event_fifo: scoreboard of sent events, checked by a downstream responder.
module tb_aer_out_event_fifo;

    localparam int AW    = 11;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          AERIN_REQ;
    logic [AW-1:0] AERIN_ADDR;
    logic          AERIN_ACK;
    logic          AEROUT_REQ;
    logic [AW-1:0] AEROUT_ADDR;
    logic          AEROUT_ACK;
    logic          FLUSH;
    logic [LW-1:0] LEVEL;
    logic          FULL;
    logic          EMPTY;
    logic [31:0]   EVT_CNT;
    logic [LW-1:0] MAX_LEVEL;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] sb[$];
    bit  rsp_en    = 1'b0;
    bit  rsp_rand  = 1'b0;
    int  rsp_delay = 0;
    bit  rsp_seen  = 1'b0;
    int  rsp_cnt   = 0;
    bit  mon_en    = 1'b0;

    aer_out_event_fifo #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LVL_WIDTH(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .AERIN_REQ  (AERIN_REQ),
        .AERIN_ADDR (AERIN_ADDR),
        .AERIN_ACK  (AERIN_ACK),
        .AEROUT_REQ (AEROUT_REQ),
        .AEROUT_ADDR(AEROUT_ADDR),
        .AEROUT_ACK (AEROUT_ACK),
        .FLUSH      (FLUSH),
        .LEVEL      (LEVEL),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .EVT_CNT    (EVT_CNT),
        .MAX_LEVEL  (MAX_LEVEL)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Downstream responder: checks each presented word against the scoreboard head, then acks.
    initial begin
        AEROUT_ACK = 1'b0;
        forever begin
            @(negedge clk);
            if (AEROUT_ACK) begin
                if (!AEROUT_REQ) AEROUT_ACK = 1'b0;
            end else if (AEROUT_REQ && rsp_en) begin
                if (!rsp_seen) begin
                    rsp_seen = 1'b1;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL out_unexpected: got %h with empty scoreboard", AEROUT_ADDR);
                    end else begin
                        logic [AW-1:0] exp;
                        exp = sb.pop_front();
                        if (AEROUT_ADDR !== exp) begin
                            failures++;
                            $display("FAIL out_order: got %h expected %h", AEROUT_ADDR, exp);
                        end
                    end
                    rsp_cnt = rsp_rand ? int'($urandom_range(0, 5)) : rsp_delay;
                end
                if (rsp_cnt == 0) begin
                    AEROUT_ACK = 1'b1;
                    rsp_seen   = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end
        end
    end

    // Flag invariants on every cycle once out of the initial reset.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (FULL !== (LEVEL == LW'(DEPTH)) || EMPTY !== (LEVEL == '0) || LEVEL > LW'(DEPTH)) begin
                    failures++;
                    $display("FAIL flags: level=%0d full=%b empty=%b", LEVEL, FULL, EMPTY);
                end
            end
        end
    end

    task automatic send_event(input logic [AW-1:0] a);
        int n;
        @(negedge clk);
        AERIN_ADDR = a;
        AERIN_REQ  = 1'b1;
        sb.push_back(a);
        n = 0;
        while (AERIN_ACK !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (AERIN_ACK !== 1'b1) begin
            failures++;
            $display("FAIL send_ack: addr=%h ack=%b expected 1", a, AERIN_ACK);
        end
        AERIN_REQ = 1'b0;
        n = 0;
        while (AERIN_ACK !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (AERIN_ACK !== 1'b0) begin
            failures++;
            $display("FAIL send_release: addr=%h ack=%b expected 0", a, AERIN_ACK);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || AEROUT_REQ !== 1'b0 || AEROUT_ACK !== 1'b0 || EMPTY !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || AEROUT_REQ !== 1'b0 || EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL %s_drain: pending=%0d req=%b empty=%b expected 0/0/1", name, sb.size(), AEROUT_REQ, EMPTY);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; AERIN_REQ = 1'b0; AERIN_ADDR = '0; FLUSH = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (AERIN_ACK !== 1'b0 || AEROUT_REQ !== 1'b0 || AEROUT_ADDR !== '0 || LEVEL !== '0 ||
            FULL !== 1'b0 || EMPTY !== 1'b1 || EVT_CNT !== '0 || MAX_LEVEL !== '0) begin
            failures++;
            $display("FAIL reset_values: ack=%b req=%b addr=%h lvl=%0d full=%b empty=%b cnt=%0d max=%0d expected 0 0 0 0 0 1 0 0",
                     AERIN_ACK, AEROUT_REQ, AEROUT_ADDR, LEVEL, FULL, EMPTY, EVT_CNT, MAX_LEVEL);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        rsp_en = 1'b1; rsp_rand = 1'b0; rsp_delay = 2;
        @(negedge clk);
        AERIN_ADDR = 11'h2A5;
        AERIN_REQ  = 1'b1;
        sb.push_back(11'h2A5);
        @(negedge clk);
        checks++;
        if (AERIN_ACK !== 1'b1 || LEVEL !== 5'd1 || AEROUT_REQ !== 1'b0) begin
            failures++;
            $display("FAIL single_ack: ack=%b lvl=%0d oreq=%b expected 1 1 0", AERIN_ACK, LEVEL, AEROUT_REQ);
        end
        AERIN_REQ = 1'b0;
        @(negedge clk);
        checks++;
        if (AEROUT_REQ !== 1'b1 || AEROUT_ADDR !== 11'h2A5 || LEVEL !== 5'd0 || AERIN_ACK !== 1'b0) begin
            failures++;
            $display("FAIL single_present: oreq=%b addr=%h lvl=%0d ack=%b expected 1 2a5 0 0",
                     AEROUT_REQ, AEROUT_ADDR, LEVEL, AERIN_ACK);
        end
        n = 0;
        while (AEROUT_REQ === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL single_req_len: req dropped after %0d cycles expected 3", n);
        end
        wait_drain("single");
    endtask

    task automatic test_fill();
        int n;
        rsp_en = 1'b0; rsp_delay = 0;
        for (int i = 0; i < 17; i++) send_event(AW'(i));
        @(negedge clk);
        checks++;
        if (FULL !== 1'b1 || LEVEL !== 5'd16 || AEROUT_REQ !== 1'b1) begin
            failures++;
            $display("FAIL fill_full: full=%b lvl=%0d oreq=%b expected 1 16 1", FULL, LEVEL, AEROUT_REQ);
        end
        AERIN_ADDR = 11'd17;
        AERIN_REQ  = 1'b1;
        sb.push_back(11'd17);
        repeat (6) @(negedge clk);
        checks++;
        if (AERIN_ACK !== 1'b0 || LEVEL !== 5'd16) begin
            failures++;
            $display("FAIL fill_backpressure: ack=%b lvl=%0d expected 0 16", AERIN_ACK, LEVEL);
        end
        rsp_en = 1'b1;
        n = 0;
        while (AERIN_ACK !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (AERIN_ACK !== 1'b1) begin
            failures++;
            $display("FAIL fill_accept18: ack=%b expected 1", AERIN_ACK);
        end
        AERIN_REQ = 1'b0;
        wait_drain("fill");
    endtask

    task automatic test_wrap();
        rsp_en = 1'b1; rsp_rand = 1'b1;
        for (int i = 0; i < 40; i++) send_event(AW'(i * 37 + 5));
        wait_drain("wrap");
        rsp_rand = 1'b0;
    endtask

    task automatic test_flush();
        int  n;
        bit  rose;
        rsp_en = 1'b0;
        for (int i = 0; i < 6; i++) send_event(AW'(11'h100 + i));
        checks++;
        if (LEVEL !== 5'd5 || AEROUT_REQ !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup: lvl=%0d oreq=%b expected 5 1", LEVEL, AEROUT_REQ);
        end
        @(negedge clk); FLUSH = 1'b1;
        @(negedge clk); FLUSH = 1'b0;
        checks++;
        if (LEVEL !== 5'd0 || EMPTY !== 1'b1 || AEROUT_REQ !== 1'b1 || AEROUT_ADDR !== 11'h100) begin
            failures++;
            $display("FAIL flush_level: lvl=%0d empty=%b oreq=%b addr=%h expected 0 1 1 100",
                     LEVEL, EMPTY, AEROUT_REQ, AEROUT_ADDR);
        end
        while (sb.size() > 1) void'(sb.pop_back());
        rsp_delay = 1;
        rsp_en    = 1'b1;
        n = 0;
        while ((sb.size() != 0 || AEROUT_REQ !== 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        rose = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (AEROUT_REQ !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose || sb.size() != 0) begin
            failures++;
            $display("FAIL flush_quiet: extra_req=%b pending=%0d expected 0 0", rose, sb.size());
        end
        rsp_delay = 0;
        wait_drain("flush");
    endtask

    task automatic test_flush_collision();
        rsp_en = 1'b0;
        for (int i = 0; i < 3; i++) send_event(AW'(11'h011 + i));
        @(negedge clk);
        AERIN_ADDR = 11'h07F;
        AERIN_REQ  = 1'b1;
        FLUSH      = 1'b1;
        @(negedge clk);
        FLUSH = 1'b0;
        checks++;
        if (LEVEL !== 5'd1 || AERIN_ACK !== 1'b1 || EMPTY !== 1'b0) begin
            failures++;
            $display("FAIL collide_level: lvl=%0d ack=%b empty=%b expected 1 1 0", LEVEL, AERIN_ACK, EMPTY);
        end
        AERIN_REQ = 1'b0;
        void'(sb.pop_back());
        void'(sb.pop_back());
        sb.push_back(11'h07F);
        rsp_en = 1'b1;
        wait_drain("collide");
    endtask

    task automatic test_reset_abort();
        rsp_en = 1'b0;
        for (int i = 0; i < 3; i++) send_event(AW'(11'h300 + i));
        @(negedge clk);
        AERIN_ADDR = 11'h3FF;
        AERIN_REQ  = 1'b1;
        @(negedge clk);
        checks++;
        if (AERIN_ACK !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup: ack=%b expected 1", AERIN_ACK);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (AERIN_ACK !== 1'b0 || AEROUT_REQ !== 1'b0 || AEROUT_ADDR !== '0 || LEVEL !== '0 || EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL abort_reset: ack=%b oreq=%b addr=%h lvl=%0d empty=%b expected 0 0 0 0 1",
                     AERIN_ACK, AEROUT_REQ, AEROUT_ADDR, LEVEL, EMPTY);
        end
        @(negedge clk);
        AERIN_REQ = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_en = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (AEROUT_REQ !== 1'b0 || LEVEL !== '0) begin
            failures++;
            $display("FAIL abort_discard: oreq=%b lvl=%0d expected 0 0", AEROUT_REQ, LEVEL);
        end
    endtask

    task automatic test_stats();
        logic [31:0]   exp_cnt;
        logic [LW-1:0] exp_max;
`ifdef AER_FIFO_STATS_EN
        exp_cnt = 32'd10;
        exp_max = 5'd4;
`else
        exp_cnt = 32'd0;
        exp_max = 5'd0;
`endif
        rsp_en = 1'b0; rsp_delay = 0;
        for (int i = 0; i < 5; i++) send_event(AW'(11'h500 + i));
        checks++;
        if (LEVEL !== 5'd4) begin
            failures++;
            $display("FAIL stats_peak: lvl=%0d expected 4", LEVEL);
        end
        rsp_en = 1'b1;
        wait_drain("stats_a");
        for (int i = 0; i < 5; i++) send_event(AW'(11'h600 + i));
        wait_drain("stats_b");
        checks++;
        if (EVT_CNT !== exp_cnt || MAX_LEVEL !== exp_max) begin
            failures++;
            $display("FAIL stats_count: cnt=%0d max=%0d expected %0d %0d", EVT_CNT, MAX_LEVEL, exp_cnt, exp_max);
        end
        @(negedge clk); FLUSH = 1'b1;
        @(negedge clk); FLUSH = 1'b0;
        @(negedge clk);
        checks++;
        if (EVT_CNT !== exp_cnt || MAX_LEVEL !== exp_max) begin
            failures++;
            $display("FAIL stats_after_flush: cnt=%0d max=%0d expected %0d %0d", EVT_CNT, MAX_LEVEL, exp_cnt, exp_max);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_flush();
        test_flush_collision();
        test_reset_abort();
        test_stats();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aer_out_event_fifo.md
# aer_out_event_fifo

Elastic buffer on the output AER path of the LRF core-array top level. It accepts events from the core-event arbiter through a same-clock 4-phase handshake and stores them in a power-of-two FIFO. It re-emits them in order through a second 4-phase handshake toward the next layer's AER input. A stalled downstream then back-pressures the arbiter instead of blocking individual cores mid-sample.

## Interface
- ADDR_WIDTH, 11, event word width: {core index, 2-bit type, neuron index}; default fits 64 cores × 8 channels.
- DEPTH, 16, FIFO storage entries; power of two, ≥2.
- LVL_WIDTH, $clog2(DEPTH)+1, width of occupancy outputs.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- AERIN_REQ  in  1  upstream event request (from arbiter evt_req).
- AERIN_ADDR  in  ADDR_WIDTH  upstream event word; stable while AERIN_REQ high.
- AERIN_ACK  out  1  upstream acknowledge.
- AEROUT_REQ  out  1  downstream event request.
- AEROUT_ADDR  out  ADDR_WIDTH  downstream event word; stable while AEROUT_REQ high.
- AEROUT_ACK  in  1  downstream acknowledge.
- FLUSH  in  1  synchronous single-cycle clear of stored (not yet presented) events.
- LEVEL  out  LVL_WIDTH  storage occupancy, 0..DEPTH.
- FULL  out  1  LEVEL==DEPTH.
- EMPTY  out  1  LEVEL==0.
- EVT_CNT  out  32  accepted-event count (stats build only).
- MAX_LEVEL  out  LVL_WIDTH  high-water mark of LEVEL (stats build only).

## Operation
- Structure: DEPTH-entry circular buffer (wr_ptr, rd_ptr, LVL_WIDTH bits each, MSB = wrap bit) plus one output holding register (out_vld, out_addr). Total capacity DEPTH+1 events.
- Input FSM, IN_IDLE → IN_ACK → IN_IDLE:
  - IN_IDLE: AERIN_REQ=1 and FULL=0 → write AERIN_ADDR at wr_ptr, wr_ptr++, AERIN_ACK←1, go to IN_ACK.
  - FULL=1: no write and ACK stays 0. This is lossless back-pressure.
  - IN_ACK: hold ACK=1 until AERIN_REQ=0, then ACK←0 and go to IN_IDLE.
- Output FSM, OUT_IDLE → OUT_REQ → OUT_WAIT → OUT_IDLE:
  - OUT_IDLE: storage non-empty and FLUSH=0 → load out_addr from rd_ptr, rd_ptr++, AEROUT_REQ←1, go to OUT_REQ.
  - OUT_REQ: AEROUT_ACK=1 → AEROUT_REQ←0, go to OUT_WAIT.
  - OUT_WAIT: AEROUT_ACK=0 → OUT_IDLE.
- Order is strictly FIFO. Event words pass through unmodified; the type field is not interpreted.
- Same-cycle write and read-to-output are both allowed. LEVEL changes by +1, −1 or 0 accordingly.
- FLUSH: rd_ptr←wr_ptr, so storage becomes empty.
  - An event already in the output register (AEROUT_REQ high) completes its handshake normally.
  - A write in the same cycle as FLUSH survives: LEVEL=1 afterwards. The write lands at the old wr_ptr, and rd_ptr is set to that position.
  - A load into the output register is suppressed in the FLUSH cycle.
- Pointer wrap: index = ptr[LVL_WIDTH-2:0]. FULL is detected by equal indices with differing wrap bits.

## Timing
- Reset values: AERIN_ACK=0, AEROUT_REQ=0, AEROUT_ADDR=0, LEVEL=0, FULL=0, EMPTY=1, EVT_CNT=0, MAX_LEVEL=0. Pointers are 0 and both FSMs are idle.
- Reset mid-handshake aborts both sides immediately and discards all events.
- Latency, empty buffer:
  - AERIN_REQ sampled high at edge t → AERIN_ACK=1 and LEVEL=1 after edge t.
  - AEROUT_REQ=1 after edge t+1, with LEVEL back to 0.
- AEROUT_ACK sampled high at edge u → AEROUT_REQ=0 after edge u.
- The next AEROUT_REQ comes no earlier than one cycle after AEROUT_ACK is seen low.
- Maximum throughput: one event per 3 cycles per side.
- LEVEL, FULL and EMPTY are registered and reflect the pointers after the edge.

## Configuration
- AER_FIFO_STATS_EN defined:
  - EVT_CNT increments on every accepted input event and wraps at 2^32.
  - MAX_LEVEL ← max(MAX_LEVEL, LEVEL_next) every cycle.
  - FLUSH clears neither counter; only rst_n does.
- Undefined: counter logic is absent, and EVT_CNT and MAX_LEVEL are tied to 0.

## Test plan
- Single event: AERIN_ADDR=11'h2A5, REQ held until ACK, downstream ACKs after 2 cycles → AERIN_ACK rises 1 cycle after REQ. AEROUT_REQ rises 2 cycles after REQ with AEROUT_ADDR=11'h2A5. LEVEL returns to 0.
- Fill with AEROUT_ACK tied 0: send 18 events 0..17 → 17 acknowledged (16 stored plus 1 in output). FULL=1 and LEVEL=16. The 18th request stays unacknowledged until the first downstream ACK, then is accepted. Output order is 0..17.
- Wrap-around: 40 events with random downstream ACK delays of 0-5 cycles → output sequence identical to input, and no FULL while LEVEL<16.
- FLUSH: with 5 stored events and one presented (AEROUT_REQ high), pulse FLUSH → LEVEL=0 next cycle. The presented event completes, then AEROUT_REQ stays 0.
- FLUSH colliding with an input write of 11'h07F → LEVEL=1 afterwards and 11'h07F is the next event output.
- Stats build: 10 events with peak occupancy 4 → EVT_CNT=10 and MAX_LEVEL=4, both unchanged after FLUSH. Non-stats build: both read 0.
